// File: rtl/selector_pkg.sv
// Shared types and defaults for the selector sprite ROM arbiter.
package selector_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 4;
    // Wide enough to hold the largest legal ROM latency (4)
    localparam int LAT_CNT_W  = 3;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_WAIT   = 2'd1,
        ARB_FLIGHT = 2'd2,
        ARB_RESP   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/lat_pipe.sv
// DEPTH-deep single-bit valid shift register with synchronous active-low clear.
module lat_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] sr_q;

    // Shift the request bit toward the tail once per clock
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sr_q <= {DEPTH{1'b0}};
        end else begin
            sr_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/selector_rom_arbiter.sv
// Shares the selector ROM read port: display fetches always win, game-logic
// reads are slotted into cycles with no display fetch.
module selector_rom_arbiter
    import selector_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ROM_LAT = 1
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              pix_req,
    input  logic [ADDR_W-1:0] pix_addr,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix_q,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              cpu_rready,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_q
);

    localparam logic [LAT_CNT_W-1:0] ROM_LAT_CNT = LAT_CNT_W'(ROM_LAT);
    localparam logic [LAT_CNT_W-1:0] CNT_ONE     = LAT_CNT_W'(1);

    arb_state_t           state_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [LAT_CNT_W-1:0] cnt_q;
    logic [DATA_W-1:0]    rdata_q;
    logic                 rvalid_q;
    logic                 ready_q;
    logic                 accept_s;
    logic                 grant_s;

    assign accept_s = (state_q == ARB_IDLE) && ready_q && cpu_req;
    assign grant_s  = (state_q == ARB_WAIT) && !pix_req;

    // When nobody is granted the port simply follows the display address
    assign rom_address = grant_s ? addr_q : pix_addr;

    // Logic-side request FSM; rdata is captured on the last FLIGHT cycle,
    // when rom_q still holds the word addressed at grant time
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            state_q  <= ARB_IDLE;
            addr_q   <= {ADDR_W{1'b0}};
            cnt_q    <= {LAT_CNT_W{1'b0}};
            rdata_q  <= {DATA_W{1'b0}};
            rvalid_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            ready_q <= (state_q == ARB_IDLE) && !accept_s;
            case (state_q)
                ARB_IDLE: begin
                    if (accept_s) begin
                        addr_q  <= cpu_addr;
                        state_q <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (grant_s) begin
                        cnt_q   <= ROM_LAT_CNT;
                        state_q <= ARB_FLIGHT;
                    end
                end
                ARB_FLIGHT: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        rdata_q  <= rom_q;
                        rvalid_q <= 1'b1;
                        state_q  <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    if (cpu_rready) begin
                        rvalid_q <= 1'b0;
                        state_q  <= ARB_IDLE;
                    end
                end
                default: begin
                    rvalid_q <= 1'b0;
                    state_q  <= ARB_IDLE;
                end
            endcase
        end
    end

    assign cpu_ready  = ready_q;
    assign cpu_rvalid = rvalid_q;
    assign cpu_rdata  = rdata_q;
    assign pix_q      = rom_q;

    lat_pipe #(
        .DEPTH(ROM_LAT)
    ) u_pix_pipe (
        .clk_i (vga_clk),
        .rst_ni(reset_n),
        .d_i   (pix_req),
        .q_o   (pix_valid)
    );

endmodule

// File: tb/tb_selector_rom_arbiter.sv
// Randomised scoreboard bench: two arbiter instances (ROM latency 1 and 3),
// each with its own ROM model, reference model and output monitor.
module tb_selector_rom_arbiter;

    typedef struct {
        int         cyc;
        logic [3:0] data;
    } exp_t;

    logic clk = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [3:0] rom_fn(input logic [7:0] a);
        return a[3:0] ^ 4'hA;
    endfunction

    task automatic chk(input string name, input int ln, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s lane %0d t=%0t: got %0h expected %0h", name, ln, $time, act, req);
        end
    endtask

    task automatic bound_fail(input string name, input int ln);
        total++;
        bad++;
        $display("FAIL %s lane %0d t=%0t: got no event expected event within bound", name, ln, $time);
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LAT = (g == 0) ? 1 : 3;

        logic       reset_n, pix_req, pix_valid, cpu_req, cpu_ready, cpu_rvalid, cpu_rready;
        logic [7:0] pix_addr, cpu_addr, rom_address;
        logic [3:0] pix_q, cpu_rdata, rom_q;
        logic [3:0] rom_pipe [0:LAT-1];

        exp_t       pix_exp[$];
        exp_t       cpu_exp[$];
        exp_t       mon_e;
        exp_t       push_e;
        int         cyc         = 0;
        int         ready_from  = 0;
        int         rvalid_from = 0;
        bit         started     = 1'b0;
        bit         m_busy      = 1'b0;
        bit         m_wait      = 1'b0;
        bit         m_flight    = 1'b0;
        bit         prev_rvalid = 1'b0;
        logic [7:0] m_addr      = 8'h00;
        logic [3:0] m_rdata     = 4'h0;
        bit         done        = 1'b0;

        selector_rom_arbiter #(
            .ADDR_W (8),
            .DATA_W (4),
            .ROM_LAT(LAT)
        ) dut (
            .vga_clk    (clk),
            .reset_n    (reset_n),
            .pix_req    (pix_req),
            .pix_addr   (pix_addr),
            .pix_valid  (pix_valid),
            .pix_q      (pix_q),
            .cpu_req    (cpu_req),
            .cpu_addr   (cpu_addr),
            .cpu_ready  (cpu_ready),
            .cpu_rvalid (cpu_rvalid),
            .cpu_rdata  (cpu_rdata),
            .cpu_rready (cpu_rready),
            .rom_address(rom_address),
            .rom_q      (rom_q)
        );

        // Behavioural ROM: address seen in cycle c appears on rom_q in cycle c+LAT
        always @(posedge clk) begin
            rom_pipe[0] <= rom_fn(rom_address);
            for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
        end
        assign rom_q = rom_pipe[LAT-1];

        // Reference model: timestamps of accept, grant and response per the rules
        always @(posedge clk) begin
            if (!reset_n) begin
                started    = 1'b1;
                m_busy     = 1'b0;
                m_wait     = 1'b0;
                m_flight   = 1'b0;
                m_rdata    = 4'h0;
                ready_from = cyc + 2;
                pix_exp.delete();
                cpu_exp.delete();
            end else if (started) begin
                if (pix_req) begin
                    push_e.cyc  = cyc + LAT;
                    push_e.data = rom_fn(pix_addr);
                    pix_exp.push_back(push_e);
                end
                if (m_flight && cyc >= rvalid_from && cpu_rready) begin
                    m_flight   = 1'b0;
                    m_busy     = 1'b0;
                    ready_from = cyc + 2;
                end
                if (m_wait && !pix_req) begin
                    m_wait      = 1'b0;
                    m_flight    = 1'b1;
                    rvalid_from = cyc + LAT + 1;
                    push_e.cyc  = rvalid_from;
                    push_e.data = rom_fn(m_addr);
                    cpu_exp.push_back(push_e);
                end
                if (!m_busy && cyc >= ready_from && cpu_req) begin
                    m_busy = 1'b1;
                    m_wait = 1'b1;
                    m_addr = cpu_addr;
                end
            end
            cyc = cyc + 1;
        end

        // Monitor: compares DUT outputs mid-cycle against the model and queues
        always @(negedge clk) begin
            if (started) begin
                chk("cpu_ready", g, 32'(cpu_ready), 32'(!m_busy && cyc >= ready_from));
                chk("cpu_rvalid", g, 32'(cpu_rvalid), 32'(m_flight && cyc >= rvalid_from));
                chk("rom_address", g, 32'(rom_address), 32'((m_wait && !pix_req) ? m_addr : pix_addr));
                if (pix_valid) begin
                    if (pix_exp.size() == 0 || pix_exp[0].cyc != cyc) begin
                        chk("pix_valid_extra", g, 32'(pix_valid), 32'd0);
                    end else begin
                        mon_e = pix_exp.pop_front();
                        chk("pix_q", g, 32'(pix_q), 32'(mon_e.data));
                    end
                end else if (pix_exp.size() > 0 && pix_exp[0].cyc <= cyc) begin
                    mon_e = pix_exp.pop_front();
                    chk("pix_valid_missing", g, 32'(pix_valid), 32'd1);
                end
                if (cpu_rvalid && !prev_rvalid) begin
                    if (cpu_exp.size() == 0) begin
                        chk("cpu_rvalid_extra", g, 32'(cpu_rvalid), 32'd0);
                    end else begin
                        mon_e = cpu_exp.pop_front();
                        chk("cpu_rvalid_cycle", g, 32'(cyc), 32'(mon_e.cyc));
                        m_rdata = mon_e.data;
                    end
                end
                chk("cpu_rdata", g, 32'(cpu_rdata), 32'(m_rdata));
                prev_rvalid = cpu_rvalid;
            end
        end

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        task automatic cpu_issue(input logic [7:0] a);
            bit ok;
            ok       = 1'b0;
            cpu_req  = 1'b1;
            cpu_addr = a;
            for (int n = 0; n < 500 && !ok; n++) begin
                @(negedge clk);
                ok = cpu_ready;
                step();
            end
            cpu_req = 1'b0;
            if (!ok) bound_fail("cpu_accept", g);
        endtask

        task automatic wait_rvalid();
            bit ok;
            ok = 1'b0;
            for (int n = 0; n < 500 && !ok; n++) begin
                @(negedge clk);
                ok = cpu_rvalid;
            end
            if (!ok) bound_fail("cpu_rvalid_wait", g);
            step();
        endtask

        initial begin
            reset_n    = 1'b0;
            pix_req    = 1'b0;
            pix_addr   = 8'h00;
            cpu_req    = 1'b0;
            cpu_addr   = 8'h00;
            cpu_rready = 1'b0;
            step();
            step();
            reset_n = 1'b1;
            repeat (4) step();

            // Back-to-back display burst over addresses 0..15
            for (int i = 0; i < 16; i++) begin
                pix_req  = 1'b1;
                pix_addr = 8'(i);
                step();
            end
            pix_req = 1'b0;
            repeat (LAT + 2) step();

            // Logic read in blanking
            cpu_rready = 1'b1;
            cpu_issue(8'h3C);
            wait_rvalid();
            repeat (3) step();

            // Logic read held off by 40 cycles of continuous display fetches
            fork
                begin
                    for (int i = 0; i < 40; i++) begin
                        pix_req  = 1'b1;
                        pix_addr = 8'(8'h80 + i);
                        step();
                    end
                    pix_req = 1'b0;
                end
                cpu_issue(8'h05);
            join
            wait_rvalid();
            repeat (3) step();

            // Response held for 10 cycles of back-pressure
            cpu_rready = 1'b0;
            cpu_issue(8'(($urandom_range(0, 255))));
            wait_rvalid();
            repeat (10) step();
            cpu_rready = 1'b1;
            step();
            repeat (4) step();

            // Random mix of display traffic with periodic blanking and logic reads
            fork
                begin
                    for (int i = 0; i < 400; i++) begin
                        pix_req  = ((i % 50) < 40) && ($urandom_range(0, 3) != 0);
                        pix_addr = 8'($urandom_range(0, 255));
                        step();
                    end
                    pix_req = 1'b0;
                end
                begin
                    for (int k = 0; k < 10; k++) begin
                        cpu_issue(8'($urandom_range(0, 255)));
                        repeat ($urandom_range(0, 5)) step();
                    end
                end
                begin
                    for (int i = 0; i < 450; i++) begin
                        cpu_rready = ($urandom_range(0, 1) != 0);
                        step();
                    end
                    cpu_rready = 1'b1;
                end
            join
            pix_req    = 1'b0;
            cpu_rready = 1'b1;
            repeat (20) step();

            // Reset pulse while the logic read is in FLIGHT
            pix_req  = 1'b1;
            pix_addr = 8'h33;
            cpu_issue(8'h77);
            pix_req = 1'b0;
            step();
            pix_req  = 1'b1;
            pix_addr = 8'h44;
            reset_n  = 1'b0;
            step();
            reset_n = 1'b1;
            pix_req = 1'b0;
            repeat (15) step();
            done = 1'b1;
        end
    end

    initial begin
        bit all_done;
        all_done = 1'b0;
        for (int n = 0; n < 20000 && !all_done; n++) begin
            @(posedge clk);
            all_done = lane[0].done && lane[1].done;
        end
        if (!all_done) bound_fail("stimulus_finish", 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/selector_rom_arbiter.md
# selector_rom_arbiter

Shares the single read port of the selector sprite ROM between two requesters. The display path issues one pixel fetch per `vga_clk` during active video and must never stall. The game-logic path (collision and hit-test queries) issues occasional single-word reads through a valid/ready handshake and is served only when the display is not fetching. The block sits between the pixel-address generator and `selector_rom`, and returns each requester its own tagged read data.

## Interface
Parameters:
- `ADDR_W`, 8: ROM address width.
- `DATA_W`, 4: ROM word (palette index) width.
- `ROM_LAT`, 1: ROM read latency in cycles, from address sampled to `rom_q` valid; legal range 1..4.

Ports:
- `vga_clk`  in  1: single clock. All logic is on its rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `pix_req`  in  1: display fetch request for this cycle.
- `pix_addr`  in  ADDR_W: display fetch address.
- `pix_valid`  out  1: `pix_q` is valid this cycle.
- `pix_q`  out  DATA_W: display read data.
- `cpu_req`  in  1: logic-side request valid.
- `cpu_addr`  in  ADDR_W: logic-side address, sampled on accept.
- `cpu_ready`  out  1: arbiter can accept a logic request.
- `cpu_rvalid`  out  1: logic-side read data valid; held until accepted.
- `cpu_rdata`  out  DATA_W: logic-side read data, stable while `cpu_rvalid`=1.
- `cpu_rready`  in  1: logic side accepts the read data.
- `rom_address`  out  ADDR_W: to the ROM address input.
- `rom_q`  in  DATA_W: from the ROM data output.

## Operation
- Priority: display always wins the ROM port. `pix_req`=1 drives `rom_address`=`pix_addr` in the same cycle (combinational mux).
- CPU FSM states are IDLE, WAIT, FLIGHT and RESP.
  - IDLE: `cpu_ready`=1. On `cpu_req`=1, latch `cpu_addr` into `addr_q` and go to WAIT.
  - WAIT: if `pix_req`=0, drive `rom_address`=`addr_q` (this is the grant), load the latency counter with `ROM_LAT`, and go to FLIGHT. Otherwise stay in WAIT.
  - FLIGHT: decrement the counter. When it reaches 0, capture `rom_q` into `cpu_rdata` and go to RESP.
  - RESP: `cpu_rvalid`=1. On `cpu_rready`=1, go to IDLE.
- FLIGHT and RESP do not use the port, so display fetches proceed freely during them.
- Only one logic request is outstanding at a time. `cpu_ready`=0 in every state except IDLE.
- Display valid pipeline: a `ROM_LAT`-deep shift register of `pix_req`. Its tail drives `pix_valid`. `pix_q`=`rom_q`, passed through unregistered.
- Port idle (no `pix_req`, no grant): `rom_address`=`pix_addr`. This is harmless and gives no extra toggling.
- Simultaneous `pix_req`=1 and FSM in WAIT: no grant. The FSM stays in WAIT, with no counter, ordering or data effect.
- There is no starvation guard. The logic side is guaranteed service in horizontal and vertical blanking, when `pix_req`=0.

## Timing
- Reset values: `pix_valid`=0, `pix_q` follows `rom_q`, `cpu_ready`=0 during reset, `cpu_rvalid`=0, `cpu_rdata`=0, state=IDLE, shift register cleared, `addr_q`=0.
- `cpu_ready`=1 from the first cycle after `reset_n` deasserts.
- Display latency: `pix_req` sampled at edge N gives `pix_valid`=1 at edge N+`ROM_LAT`. One result per cycle, back-to-back, no bubbles.
- Logic latency: accept at edge A, grant at the first edge G>A with `pix_req`=0, `cpu_rvalid` rises at edge G+`ROM_LAT`+1.
- Minimum request-to-request interval on the logic side, with `cpu_rready` tied high: `ROM_LAT`+4 cycles.
- Reset mid-operation: the in-flight logic read is dropped and no `cpu_rvalid` is produced. Shift register contents are discarded, so no stray `pix_valid`.
- `cpu_rdata` changes only on entry to RESP.

## Structure
- Shared package `selector_pkg`:
  - `ADDR_W`/`DATA_W` defaults.
  - `arb_state_t` enum (IDLE, WAIT, FLIGHT, RESP).
- Sub-module `lat_pipe`: a parameterised `ROM_LAT`-deep 1-bit valid shift register with synchronous active-low clear. It is used for `pix_valid`.
- Everything else (FSM, counter, mux, data register) lives in `selector_rom_arbiter`.

## Test plan
All scenarios use a behavioural ROM model with `mem[a]=a[3:0]^4'hA`.
- Reset release with all inputs low -> `cpu_ready`=1 next cycle; `cpu_rvalid`=0, `pix_valid`=0.
- `pix_req`=1 for 16 cycles with `pix_addr`=0..15, `ROM_LAT`=1 -> `pix_valid` high for 16 cycles starting one cycle later; `pix_q` = 0xA,0xB,0x8,0x9,…, in order.
- `cpu_req` with `addr`=0x3C while `pix_req`=0, `cpu_rready`=1 -> grant on the next cycle; `cpu_rvalid`=1 with `rdata`=0x6 at accept+3 (`ROM_LAT`=1).
- `cpu_req` `addr`=0x05 during 40 cycles of continuous `pix_req` -> FSM holds WAIT and `rom_address` tracks `pix_addr`. The grant occurs on the first `pix_req`=0 cycle, then `rdata`=0xF; display data is unaffected.
- `cpu_rready`=0 for 10 cycles after `cpu_rvalid` -> `cpu_rvalid`/`cpu_rdata` held constant and `cpu_ready`=0. After `rready`, IDLE and `cpu_ready`=1 the next cycle.
- `reset_n` low for one cycle while in FLIGHT with `ROM_LAT`=3 -> no `cpu_rvalid`, no `pix_valid` afterward; `cpu_ready`=1 one cycle after release.
